// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NCH-channel valid/ready packet mux with one output register.
// Arbitration is per packet, round-robin (RR=1) or fixed priority (RR=0).
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int RR    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH*WIDTH-1:0]     in_data,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH-1:0]           in_last,
  output logic [NCH-1:0]           in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_sel
);

  localparam int SW = $clog2(NCH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [SW-1:0]    r_gnt;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    w_gnt_n;
  logic [SW-1:0]    w_ptr_n;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SW-1:0]    r_out_sel;

  logic [SW-1:0]    w_cand;
  logic             w_found;
  logic [SW-1:0]    w_sel;
  logic             w_sel_ok;
  logic             w_slot_free;
  logic             w_grant_ok;
  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_data;

  function automatic logic [SW-1:0] f_inc(input logic [SW-1:0] x);
    return (x == SW'(NCH - 1)) ? '0 : x + 1'b1;
  endfunction

  assign w_slot_free = ~r_out_valid | out_ready;

  // Search upward from ptr with wrap; the lowest offset found wins.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int            idx;
      logic [SW-1:0] w_i;
      idx = (RR != 0) ? int'(r_ptr) + k : k;
      if (idx >= NCH) idx = idx - NCH;
      w_i = SW'(idx);
      if (in_valid[w_i]) begin
        w_cand  = w_i;
        w_found = 1'b1;
      end
    end
  end

  assign w_sel      = (r_state == S_IDLE) ? w_cand : r_gnt;
  assign w_sel_ok   = (r_state == S_IDLE) ? w_found : 1'b1;
  assign w_grant_ok = w_sel_ok & w_slot_free & ~reset;
  assign w_xfer     = w_grant_ok & in_valid[w_sel];
  assign w_last     = in_last[w_sel];
  assign w_data     = in_data[w_sel*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = w_grant_ok & (w_sel == SW'(i));
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_ptr_n   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer && !w_last) begin
          w_state_n = S_LOCK;
          w_gnt_n   = w_cand;
        end else if (w_xfer && w_last && (RR != 0)) begin
          w_ptr_n = f_inc(w_cand);
        end
      end
      S_LOCK: begin
        if (w_xfer && w_last) begin
          w_state_n = S_IDLE;
          if (RR != 0) w_ptr_n = f_inc(r_gnt);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_ptr   <= w_ptr_n;
    end
  end

  // Load wins over drain, so a beat can replace the held one with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_out_sel   <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin and a fixed-priority
// instance share stimulus; each test checks the instance it targets.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  rr_ready, fp_ready;
  logic [7:0]  rr_data, fp_data;
  logic        rr_valid, fp_valid;
  logic        rr_last, fp_last;
  logic [1:0]  rr_sel, fp_sel;

  int total = 0;
  int bad   = 0;

  logic       mon_en = 1'b0;
  logic [7:0] q_obs[$];

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .NCH(4), .RR(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rr_ready), .out_data(rr_data),
    .out_valid(rr_valid), .out_last(rr_last), .out_ready(out_ready),
    .out_sel(rr_sel)
  );

  stream_mux_rr #(.WIDTH(8), .NCH(4), .RR(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(fp_ready), .out_data(fp_data),
    .out_valid(fp_valid), .out_last(fp_last), .out_ready(out_ready),
    .out_sel(fp_sel)
  );

  always @(posedge clk) begin
    if (mon_en && rr_valid && out_ready) q_obs.push_back(rr_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int ch, input logic [7:0] d, input logic l);
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
  endtask

  task automatic chk_rr(input string tag, input logic v, input logic [7:0] d,
                        input logic l, input logic [1:0] s);
    chk({tag, "_valid"}, {31'd0, rr_valid}, {31'd0, v});
    chk({tag, "_data"}, {24'd0, rr_data}, {24'd0, d});
    chk({tag, "_last"}, {31'd0, rr_last}, {31'd0, l});
    chk({tag, "_sel"}, {30'd0, rr_sel}, {30'd0, s});
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;

    // 1: reset, then a single beat on ch2
    step();
    step();
    chk_rr("rst", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("rst_ready", {28'd0, rr_ready}, 32'h0);
    reset    = 1'b0;
    in_valid = 4'b0100;
    setd(2, 8'hA5, 1'b1);
    #1;
    chk("t1_ready", {28'd0, rr_ready}, 32'h4);
    step();
    chk_rr("t1_out", 1'b1, 8'hA5, 1'b1, 2'd2);
    in_valid = '0;
    step();
    chk("t1_drain", {31'd0, rr_valid}, 32'h0);
    chk("t1_hold", {24'd0, rr_data}, 32'hA5);

    // 2: round-robin over four always-valid channels
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) setd(i, 8'h10 + 8'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_rr($sformatf("t2_b%0d", k), 1'b1, 8'h10 + 8'(k % 4), 1'b1,
             2'(k % 4));
    end

    // 3: ch1 3-beat packet holds the lock against ch0
    in_valid = 4'b0010;
    setd(1, 8'h21, 1'b0);
    step();
    chk_rr("t3_b0", 1'b1, 8'h21, 1'b0, 2'd1);
    in_valid = 4'b0011;
    setd(0, 8'h30, 1'b1);
    setd(1, 8'h22, 1'b0);
    #1;
    chk("t3_rdy1", {28'd0, rr_ready}, 32'h2);
    step();
    chk_rr("t3_b1", 1'b1, 8'h22, 1'b0, 2'd1);
    setd(1, 8'h23, 1'b1);
    #1;
    chk("t3_rdy2", {28'd0, rr_ready}, 32'h2);
    step();
    chk_rr("t3_b2", 1'b1, 8'h23, 1'b1, 2'd1);
    in_valid = 4'b0001;
    #1;
    chk("t3_rdy3", {28'd0, rr_ready}, 32'h1);
    step();
    chk_rr("t3_ch0", 1'b1, 8'h30, 1'b1, 2'd0);

    // 4: backpressure in the middle of a ch3 packet
    in_valid = 4'b1000;
    setd(3, 8'h40, 1'b0);
    #1;
    chk("t4_rdy0", {28'd0, rr_ready}, 32'h8);
    step();
    chk_rr("t4_b0", 1'b1, 8'h40, 1'b0, 2'd3);
    mon_en    = 1'b1;
    out_ready = 1'b0;
    setd(3, 8'h41, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_stall_rdy%0d", k), {28'd0, rr_ready}, 32'h0);
      step();
      chk_rr($sformatf("t4_stall%0d", k), 1'b1, 8'h40, 1'b0, 2'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_rel_rdy", {28'd0, rr_ready}, 32'h8);
    step();
    chk_rr("t4_b1", 1'b1, 8'h41, 1'b0, 2'd3);
    setd(3, 8'h42, 1'b1);
    step();
    chk_rr("t4_b2", 1'b1, 8'h42, 1'b1, 2'd3);
    in_valid = '0;
    step();
    chk("t4_drain", {31'd0, rr_valid}, 32'h0);
    mon_en = 1'b0;
    chk("t4_sb_cnt", q_obs.size(), 32'd3);
    if (q_obs.size() == 3) begin
      chk("t4_sb0", {24'd0, q_obs[0]}, 32'h40);
      chk("t4_sb1", {24'd0, q_obs[1]}, 32'h41);
      chk("t4_sb2", {24'd0, q_obs[2]}, 32'h42);
    end

    // 5: fixed priority keeps serving ch0 over ch3
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 4'b1001;
    setd(0, 8'h50, 1'b1);
    setd(3, 8'h53, 1'b1);
    #1;
    chk("t5_rdy", {28'd0, fp_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t5_sel%0d", k), {30'd0, fp_sel}, 32'd0);
      chk($sformatf("t5_dat%0d", k), {24'd0, fp_data}, 32'h50);
    end
    in_valid = 4'b1000;
    step();
    chk("t5_ch3_sel", {30'd0, fp_sel}, 32'd3);
    chk("t5_ch3_dat", {24'd0, fp_data}, 32'h53);

    // 6: reset in the middle of a ch2 packet
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 4'b0100;
    setd(2, 8'h60, 1'b0);
    step();
    chk_rr("t6_b0", 1'b1, 8'h60, 1'b0, 2'd2);
    setd(2, 8'h61, 1'b0);
    step();
    chk_rr("t6_b1", 1'b1, 8'h61, 1'b0, 2'd2);
    setd(2, 8'h62, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_rdy", {28'd0, rr_ready}, 32'h0);
    step();
    chk_rr("t6_rst", 1'b0, 8'h00, 1'b0, 2'd0);
    reset    = 1'b0;
    in_valid = 4'b0110;
    setd(1, 8'h70, 1'b1);
    #1;
    chk("t6_rdy", {28'd0, rr_ready}, 32'h2);
    step();
    chk_rr("t6_ch1", 1'b1, 8'h70, 1'b1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit packet stream multiplexer: the registered, arbitrated generalisation of the team's 2:1 select gate. It merges NCH valid/ready input streams onto one output stream through a single output register stage. It arbitrates per packet, with either fixed priority or round-robin. It sits between multiple producer blocks and a shared downstream consumer, for example a UART TX or display path.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- NCH, 4: number of input channels, ≥2.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority (channel 0 highest).
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel beat valid.
- in_last  input  NCH  per-channel end-of-packet marker.
- in_ready  output  NCH  per-channel accept; combinational.
- out_data  output  WIDTH  registered output beat.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered end-of-packet.
- out_ready  input  1  downstream accept.
- out_sel  output  $clog2(NCH)  channel index of the beat held in the output register.

## Operation
- Transfer definitions:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- slot_free = ~out_valid | out_ready. The output register can load a beat in any cycle it is empty or being drained.
- State machine: IDLE, LOCK. It also holds a grant register gnt and a priority pointer ptr, both $clog2(NCH) bits.
- IDLE:
  - cand is the first channel i with in_valid[i]=1, searching upward from ptr with wrap (RR=1) or from 0 (RR=0).
  - in_ready[cand] = slot_free; all other in_ready bits are 0. If no channel is valid, all in_ready bits are 0.
  - On a transfer with in_last=0: go to LOCK and set gnt=cand.
  - On a transfer with in_last=1 (single-beat packet): stay in IDLE; set ptr=(cand+1) mod NCH when RR=1.
- LOCK:
  - in_ready[gnt] = slot_free; all other in_ready bits are 0. Other channels' in_valid is ignored.
  - On a transfer from gnt with in_last=1: go to IDLE; set ptr=(gnt+1) mod NCH when RR=1.
- When RR=0, ptr stays at 0 permanently.
- Output register load: on an input transfer from channel c, out_data←in_data[c], out_last←in_last[c], out_sel←c, out_valid←1.
- Output register drain: on an output transfer with no simultaneous load, out_valid←0, and data, last and sel hold their values.
- Output register stall: with out_valid=1 and out_ready=0, all outputs hold stable and every in_ready bit is 0.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on in_valid (IDLE only), out_valid and out_ready.
- Packets are never interleaved: out_sel is constant from the first beat of a packet through its last beat.
- A channel deasserting in_valid mid-packet keeps the lock; the mux waits for that channel.

## Timing
- Reset, synchronous, takes priority over everything:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - State=IDLE, ptr=0, gnt=0.
  - in_ready=0 during any cycle reset is high.
- Reset asserted mid-packet abandons the lock and discards the registered beat. The first cycle after reset behaves as a fresh IDLE cycle.
- Latency: 1 cycle. A beat accepted at edge k appears on out_* after edge k.
- Throughput: 1 beat per cycle when out_ready is held at 1, including back-to-back packets from different channels with no bubble.
- Simultaneous load and drain in the same cycle: the register is replaced and out_valid stays 1.
- Round-robin wrap: with ptr=NCH-1, the search order is NCH-1, 0, 1, ….

## Test plan
1. Reset, then single beats: assert reset for 2 cycles and check all outputs are 0. Then apply ch2 only, beat 0xA5, last=1, with out_ready=1. Expect out_data=0xA5, out_sel=2, out_last=1 one cycle after acceptance.
2. Round-robin fairness (NCH=4, RR=1): all channels continuously send 1-beat packets with data 0x10+i, out_ready=1. Expect out_sel sequence 0,1,2,3,0,… with one beat per cycle.
3. Packet lock: ch1 sends a 3-beat packet while ch0 is valid throughout. Expect out_sel=1 for 3 consecutive beats, in_ready[0]=0 during them, and ch0 granted on the next cycle.
4. Backpressure: hold out_ready=0 for 5 cycles mid-packet. Expect out_data, out_last and out_sel stable, in_ready all 0, and no beat lost or duplicated after release (checked by a scoreboard).
5. Fixed priority (RR=0): ch0 and ch3 both continuously send 1-beat packets. Expect out_sel=0 on every beat; ch3 is served only when ch0 drops in_valid.
6. Reset mid-packet: assert reset after beat 2 of a 4-beat ch2 packet. Expect out_valid=0 and IDLE on the next cycle; a subsequent ch1 packet is granted immediately, with ptr starting at 0.
